// File: rtl/counter_4_bit_up.sv
// Binary up counter with enable, synchronous clear, clamped parallel load,
// programmable terminal value and a registered wrap pulse.
module counter_4_bit_up #(
    parameter int WIDTH   = 4,
    parameter int MAX_VAL = 2**WIDTH - 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             clr,
    input  logic             load,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q,
    output logic             tc,
    output logic             wrap
);

    localparam logic [WIDTH-1:0] MAX_Q = WIDTH'(MAX_VAL);

    logic [WIDTH-1:0] q_next;
    logic             wrap_next;
    logic             at_max;

    assign at_max = (q == MAX_Q);

    always_comb begin
        q_next    = q;
        wrap_next = 1'b0;
        if (clr) begin
            q_next = '0;
        end else if (load) begin
            // Out-of-range load values clamp to 0 so q never exceeds MAX_VAL
            q_next = (d > MAX_Q) ? '0 : d;
        end else if (en) begin
            if (at_max) begin
                q_next    = '0;
                wrap_next = 1'b1;
            end else begin
                q_next = q + WIDTH'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            q    <= '0;
            wrap <= 1'b0;
        end else begin
            q    <= q_next;
            wrap <= wrap_next;
        end
    end

    assign tc = en && at_max;

endmodule

// File: tb/tb_counter_4_bit_up.sv
// Bench for counter_4_bit_up: default build and a MAX_VAL=9 build,
// vector table plus scoreboard queue checked one step after each edge.
module tb_counter_4_bit_up;

    logic       clk;
    logic       rst;
    logic       en;
    logic       clr;
    logic       load;
    logic [3:0] d;
    logic [3:0] q;
    logic       tc;
    logic       wrap;
    logic [3:0] q9;
    logic       tc9;
    logic       wrap9;

    int checks;
    int failures;

    typedef struct {
        logic       en;
        logic       clr;
        logic       load;
        logic [3:0] d;
        logic [3:0] q;
        logic       wrap;
        logic       tc;
    } vec_t;

    typedef struct {
        logic [3:0] q;
        logic       wrap;
        logic       tc;
        bit         sel;
        string      name;
    } exp_t;

    exp_t sb[$];
    exp_t cur;
    vec_t vecs[14];

    counter_4_bit_up dut (
        .clk  (clk),
        .rst  (rst),
        .en   (en),
        .clr  (clr),
        .load (load),
        .d    (d),
        .q    (q),
        .tc   (tc),
        .wrap (wrap)
    );

    counter_4_bit_up #(.WIDTH(4), .MAX_VAL(9)) dut9 (
        .clk  (clk),
        .rst  (rst),
        .en   (en),
        .clr  (clr),
        .load (load),
        .d    (d),
        .q    (q9),
        .tc   (tc9),
        .wrap (wrap9)
    );

    initial begin
        clk = 1'b0;
        forever #50 clk = ~clk;
    end

    task automatic chk(input string nm, input int act, input int req);
        checks++;
        if (act != req) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", nm, act, req);
        end
    endtask

    task automatic push(input logic [3:0] eq, input logic ew,
                        input logic et, input bit s, input string nm);
        exp_t e;
        e.q    = eq;
        e.wrap = ew;
        e.tc   = et;
        e.sel  = s;
        e.name = nm;
        sb.push_back(e);
    endtask

    task automatic drive(input logic e, input logic c, input logic l,
                         input logic [3:0] dv, input logic [3:0] eq,
                         input logic ew, input logic et, input bit s,
                         input string nm);
        @(negedge clk);
        en   = e;
        clr  = c;
        load = l;
        d    = dv;
        push(eq, ew, et, s, nm);
    endtask

    always @(posedge clk) begin
        #1;
        if (sb.size() > 0) begin
            cur = sb.pop_front();
            if (cur.sel) begin
                chk({cur.name, ".q9"}, int'(q9), int'(cur.q));
                chk({cur.name, ".wrap9"}, int'(wrap9), int'(cur.wrap));
                chk({cur.name, ".tc9"}, int'(tc9), int'(cur.tc));
            end else begin
                chk({cur.name, ".q"}, int'(q), int'(cur.q));
                chk({cur.name, ".wrap"}, int'(wrap), int'(cur.wrap));
                chk({cur.name, ".tc"}, int'(tc), int'(cur.tc));
            end
        end
    end

    initial begin
        checks   = 0;
        failures = 0;
        //           en    clr   load  d     q     wrap  tc
        vecs[0]  = '{1'b0, 1'b0, 1'b0, 4'd0, 4'd3, 1'b0, 1'b0};
        vecs[1]  = '{1'b0, 1'b0, 1'b0, 4'd0, 4'd3, 1'b0, 1'b0};
        vecs[2]  = '{1'b0, 1'b0, 1'b0, 4'd0, 4'd3, 1'b0, 1'b0};
        vecs[3]  = '{1'b0, 1'b0, 1'b0, 4'd0, 4'd3, 1'b0, 1'b0};
        vecs[4]  = '{1'b1, 1'b0, 1'b0, 4'd0, 4'd4, 1'b0, 1'b0};
        vecs[5]  = '{1'b0, 1'b0, 1'b1, 4'd9, 4'd9, 1'b0, 1'b0};
        vecs[6]  = '{1'b0, 1'b1, 1'b1, 4'd4, 4'd0, 1'b0, 1'b0};
        vecs[7]  = '{1'b1, 1'b0, 1'b1, 4'd7, 4'd7, 1'b0, 1'b0};
        vecs[8]  = '{1'b1, 1'b0, 1'b0, 4'd0, 4'd8, 1'b0, 1'b0};
        vecs[9]  = '{1'b0, 1'b0, 1'b1, 4'd15, 4'd15, 1'b0, 1'b0};
        vecs[10] = '{1'b1, 1'b0, 1'b0, 4'd0, 4'd0, 1'b1, 1'b0};
        vecs[11] = '{1'b0, 1'b0, 1'b0, 4'd0, 4'd0, 1'b0, 1'b0};
        vecs[12] = '{1'b1, 1'b1, 1'b0, 4'd0, 4'd0, 1'b0, 1'b0};
        vecs[13] = '{1'b1, 1'b0, 1'b1, 4'd14, 4'd14, 1'b0, 1'b0};

        rst  = 1'b0;
        en   = 1'b1;
        clr  = 1'b0;
        load = 1'b0;
        d    = 4'd0;

        #75;
        chk("reset.q", int'(q), 0);
        chk("reset.wrap", int'(wrap), 0);
        chk("reset.tc", int'(tc), 0);

        @(negedge clk);
        rst = 1'b1;
        push(4'd1, 1'b0, 1'b0, 1'b0, "rel1");
        drive(1'b1, 1'b0, 1'b0, 4'd0, 4'd2, 1'b0, 1'b0, 1'b0, "rel2");
        drive(1'b1, 1'b0, 1'b0, 4'd0, 4'd3, 1'b0, 1'b0, 1'b0, "rel3");

        for (int i = 0; i < 14; i++) begin
            drive(vecs[i].en, vecs[i].clr, vecs[i].load, vecs[i].d,
                  vecs[i].q, vecs[i].wrap, vecs[i].tc, 1'b0,
                  $sformatf("vec%0d", i));
        end

        drive(1'b0, 1'b1, 1'b0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0, "wclr");
        for (int i = 1; i <= 16; i++) begin
            drive(1'b1, 1'b0, 1'b0, 4'd0, 4'(i % 16), i == 16, i == 15,
                  1'b0, $sformatf("wrap%0d", i));
        end
        drive(1'b0, 1'b0, 1'b0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0, "wpost");

        drive(1'b0, 1'b1, 1'b0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0, "aclr");
        for (int i = 1; i <= 5; i++) begin
            drive(1'b1, 1'b0, 1'b0, 4'd0, 4'(i), 1'b0, 1'b0, 1'b0,
                  $sformatf("acnt%0d", i));
        end
        @(negedge clk);
        #10;
        rst = 1'b0;
        #1;
        chk("async.q", int'(q), 0);
        chk("async.wrap", int'(wrap), 0);
        @(negedge clk);
        chk("async_hold.q", int'(q), 0);
        rst = 1'b1;
        push(4'd1, 1'b0, 1'b0, 1'b0, "arel1");
        drive(1'b1, 1'b0, 1'b0, 4'd0, 4'd2, 1'b0, 1'b0, 1'b0, "arel2");

        drive(1'b0, 1'b1, 1'b0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b1, "m9clr");
        for (int i = 1; i <= 10; i++) begin
            drive(1'b1, 1'b0, 1'b0, 4'd0, 4'(i % 10), i == 10, i == 9,
                  1'b1, $sformatf("m9cnt%0d", i));
        end
        drive(1'b0, 1'b0, 1'b1, 4'd12, 4'd0, 1'b0, 1'b0, 1'b1, "m9ld12");
        drive(1'b0, 1'b0, 1'b1, 4'd9, 4'd9, 1'b0, 1'b0, 1'b1, "m9ld9");
        drive(1'b1, 1'b0, 1'b1, 4'd10, 4'd0, 1'b0, 1'b0, 1'b1, "m9ld10");
        drive(1'b1, 1'b0, 1'b0, 4'd0, 4'd1, 1'b0, 1'b0, 1'b1, "m9inc");

        repeat (3) @(posedge clk);
        #5;
        chk("sb_drain", sb.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
